// File: rtl/signed_cplx_round_sat_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signed_cplx_round_sat_pkg : rounding-mode encoding shared by FFT requantisers
// Rev 1.0
// ---------------------------------------------------------------------------
package signed_cplx_round_sat_pkg;

   typedef logic [1:0] rnd_mode_t;

   localparam rnd_mode_t RND_TRUNC   = 2'd0;
   localparam rnd_mode_t RND_HALF_UP = 2'd1;
   localparam rnd_mode_t RND_CONV    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/signed_round_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signed_round_sat : one-component round-add / shift / saturate, two stages
// Rev 1.0
// ---------------------------------------------------------------------------
module signed_round_sat
   import signed_cplx_round_sat_pkg::*;
#(
   parameter int IWIDTH = 16,
   parameter int OWIDTH = 16,
   parameter int SHIFT  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en1,
   input  logic              en2,
   input  logic [IWIDTH-1:0] x,
   input  rnd_mode_t         mode,
   output logic [OWIDTH-1:0] y,
   output logic              sat
);

   localparam logic signed [IWIDTH:0] MAXV =
      {{(IWIDTH+2-OWIDTH){1'b0}}, {(OWIDTH-1){1'b1}}};
   localparam logic signed [IWIDTH:0] MINV = ~MAXV;

   logic        [IWIDTH:0] rc;
   logic        [IWIDTH:0] sum;
   logic signed [IWIDTH:0] shifted;
   logic                   sat_hi;
   logic                   sat_lo;
   logic        [OWIDTH-1:0] y_next;

   generate
      if (SHIFT == 0) begin : g_no_round
         assign rc = '0;
      end else begin : g_round
         localparam logic [IWIDTH:0] ONE  = {{IWIDTH{1'b0}}, 1'b1};
         localparam logic [IWIDTH:0] HALF = ONE << (SHIFT - 1);
         always_comb begin
            rc = '0;
            case (mode)
               RND_HALF_UP: rc = HALF;
               // ties go up only when the kept LSB is odd
               RND_CONV:    rc = HALF - ONE + {{IWIDTH{1'b0}}, x[SHIFT]};
               default:     rc = '0;
            endcase
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sum <= '0;
      end else if (en1) begin
         sum <= {x[IWIDTH-1], x} + rc;
      end
   end

   assign shifted = $signed(sum) >>> SHIFT;
   assign sat_hi  = shifted > MAXV;
   assign sat_lo  = shifted < MINV;

   always_comb begin
      y_next = shifted[OWIDTH-1:0];
      if (sat_hi) begin
         y_next = MAXV[OWIDTH-1:0];
      end else if (sat_lo) begin
         y_next = MINV[OWIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y   <= '0;
         sat <= 1'b0;
      end else if (en2) begin
         y   <= y_next;
         sat <= sat_hi | sat_lo;
      end
   end

endmodule
`default_nettype wire

// File: rtl/signed_cplx_round_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signed_cplx_round_sat : pipelined complex requantiser with frame sat stats
// Rev 1.0
// ---------------------------------------------------------------------------
module signed_cplx_round_sat
   import signed_cplx_round_sat_pkg::*;
#(
   parameter int IWIDTH = 16,
   parameter int OWIDTH = 16,
   parameter int SHIFT  = 0,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IWIDTH-1:0] in_re,
   input  logic [IWIDTH-1:0] in_im,
   input  logic [1:0]        in_mode,
   input  logic              in_last,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [OWIDTH-1:0] out_re,
   output logic [OWIDTH-1:0] out_im,
   output logic              out_ovf,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ovf_sticky,
   input  logic              ovf_clr,
   output logic [CNT_W-1:0]  frame_ovf_cnt,
   output logic              frame_done
);

   logic             v1, v2;
   logic             last1, last2;
   logic             ld1, ld2;
   logic             en1, en2;
   logic             sat_re, sat_im;
   logic             xfer;
   logic [CNT_W-1:0] running;
   logic [CNT_W-1:0] running_inc;

   assign ld2      = !v2 | out_ready;
   assign ld1      = !v1 | ld2;
   assign in_ready = !v1 | !v2 | out_ready;
   assign en1      = ld1 & in_valid;
   assign en2      = ld2 & v1;

   signed_round_sat #(.IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .SHIFT(SHIFT)) u_re (
      .clk(clk), .rst(rst), .en1(en1), .en2(en2),
      .x(in_re), .mode(rnd_mode_t'(in_mode)), .y(out_re), .sat(sat_re)
   );

   signed_round_sat #(.IWIDTH(IWIDTH), .OWIDTH(OWIDTH), .SHIFT(SHIFT)) u_im (
      .clk(clk), .rst(rst), .en1(en1), .en2(en2),
      .x(in_im), .mode(rnd_mode_t'(in_mode)), .y(out_im), .sat(sat_im)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         last1 <= 1'b0;
         last2 <= 1'b0;
      end else begin
         if (ld1) begin
            v1 <= in_valid;
         end
         if (en1) begin
            last1 <= in_last;
         end
         if (ld2) begin
            v2 <= v1;
         end
         if (en2) begin
            last2 <= last1;
         end
      end
   end

   assign out_valid = v2;
   assign out_last  = last2;
   assign out_ovf   = sat_re | sat_im;
   assign xfer      = v2 & out_ready;

   // saturating increment so a long frame cannot wrap the count
   assign running_inc = (out_ovf && (running != {CNT_W{1'b1}})) ? running + 1'b1 : running;

   always_ff @(posedge clk) begin
      if (rst) begin
         running       <= '0;
         frame_ovf_cnt <= '0;
         frame_done    <= 1'b0;
         ovf_sticky    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (xfer) begin
            if (out_last) begin
               frame_ovf_cnt <= running_inc;
               frame_done    <= 1'b1;
               running       <= '0;
            end else begin
               running <= running_inc;
            end
         end
         if (xfer && out_ovf) begin
            ovf_sticky <= 1'b1;
         end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_signed_cplx_round_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_signed_cplx_round_sat : directed bench, SHIFT=4/OWIDTH=8 plus SHIFT=0 DUT
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_signed_cplx_round_sat;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_re, in_im;
   logic [1:0]  in_mode;
   logic        in_last, in_valid, in_ready;
   logic [7:0]  out_re, out_im;
   logic        out_ovf, out_last, out_valid, out_ready;
   logic        ovf_sticky, ovf_clr;
   logic [15:0] frame_ovf_cnt;
   logic        frame_done;

   logic [15:0] z_in_re, z_in_im;
   logic [1:0]  z_in_mode;
   logic        z_in_valid, z_in_ready;
   logic [16:0] z_out_re, z_out_im;
   logic        z_out_ovf, z_out_last, z_out_valid;
   logic        z_sticky;
   logic [15:0] z_cnt;
   logic        z_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   signed_cplx_round_sat #(.IWIDTH(16), .OWIDTH(8), .SHIFT(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_re(in_re), .in_im(in_im), .in_mode(in_mode),
      .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .out_re(out_re), .out_im(out_im), .out_ovf(out_ovf), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready), .ovf_sticky(ovf_sticky),
      .ovf_clr(ovf_clr), .frame_ovf_cnt(frame_ovf_cnt), .frame_done(frame_done)
   );

   signed_cplx_round_sat #(.IWIDTH(16), .OWIDTH(17), .SHIFT(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .in_re(z_in_re), .in_im(z_in_im), .in_mode(z_in_mode),
      .in_last(1'b0), .in_valid(z_in_valid), .in_ready(z_in_ready),
      .out_re(z_out_re), .out_im(z_out_im), .out_ovf(z_out_ovf), .out_last(z_out_last),
      .out_valid(z_out_valid), .out_ready(1'b1), .ovf_sticky(z_sticky),
      .ovf_clr(1'b0), .frame_ovf_cnt(z_cnt), .frame_done(z_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_last = 1'b0; in_mode = 2'd0; in_re = '0; in_im = '0;
      ovf_clr = 1'b0; out_ready = 1'b1;
      z_in_valid = 1'b0; z_in_re = '0; z_in_im = '0; z_in_mode = 2'd0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [15:0] re, input logic [15:0] im,
                       input logic [1:0] mode, input logic last);
      in_re = re; in_im = im; in_mode = mode; in_last = last; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({out_valid, out_re, out_im, out_ovf, out_last} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%0b re=%0d im=%0d ovf=%0b last=%0b, want all 0",
                  out_valid, out_re, out_im, out_ovf, out_last);
      end
      checks++;
      if ({ovf_sticky, frame_ovf_cnt, frame_done} !== 18'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_stats: got sticky=%0b cnt=%0d done=%0b in_ready=%0b, want 0 0 0 1",
                  ovf_sticky, frame_ovf_cnt, frame_done, in_ready);
      end
   endtask

   task automatic test_rounding();
      int          xv [3] = '{24, 40, -24};
      int          ex [3][3] = '{'{1, 2, 2}, '{2, 3, 2}, '{-2, -1, -2}};
      logic [7:0]  want;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         for (int m = 0; m < 3; m++) begin
            want = 8'(ex[i][m]);
            send(16'(xv[i]), 16'(xv[i]), 2'(m), 1'b0);
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL latency_early x=%0d m=%0d: out_valid=%0b after 1 cycle, want 0",
                        xv[i], m, out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_re !== want || out_im !== want || out_ovf !== 1'b0) begin
               errors++;
               $display("FAIL round x=%0d m=%0d: got v=%0b re=%0d im=%0d ovf=%0b, want v=1 re=im=%0d ovf=0",
                        xv[i], m, out_valid, $signed(out_re), $signed(out_im), out_ovf, $signed(want));
            end
            tick();
         end
      end
   endtask

   task automatic test_sat_sticky();
      do_reset();
      send(16'h7FF0, 16'h8000, 2'd1, 1'b0);
      tick();
      checks++;
      if (out_re !== 8'd127 || out_im !== 8'h80 || out_ovf !== 1'b1) begin
         errors++;
         $display("FAIL saturate: got re=%0d im=%0d ovf=%0b, want 127 -128 1",
                  $signed(out_re), $signed(out_im), out_ovf);
      end
      tick();
      checks++;
      if (ovf_sticky !== 1'b1) begin
         errors++;
         $display("FAIL sticky_set: got %0b, want 1", ovf_sticky);
      end
      send(16'h7FF0, 16'h0000, 2'd0, 1'b0);
      tick();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b1) begin
         errors++;
         $display("FAIL sticky_set_wins: got %0b, want 1", ovf_sticky);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL sticky_clear: got %0b, want 0", ovf_sticky);
      end
   endtask

   task automatic test_back_to_back();
      int         sent = 0;
      int         recv = 0;
      logic       held = 1'b0;
      logic [7:0] hold_re = '0, hold_im = '0;
      logic       want_rdy;
      do_reset();
      for (int c = 0; c < 200 && recv < 8; c++) begin
         out_ready = (c % 3 == 0);
         in_valid  = (sent < 8);
         in_re     = 16'(16 * (sent + 1));
         in_im     = 16'(-16 * (sent + 1));
         in_mode   = 2'd0;
         in_last   = 1'b0;
         #1;
         want_rdy = ((sent - recv) < 2) || out_ready;
         checks++;
         if (in_ready !== want_rdy) begin
            errors++;
            $display("FAIL in_ready c=%0d: got %0b, want %0b", c, in_ready, want_rdy);
         end
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_re !== hold_re || out_im !== hold_im) begin
               errors++;
               $display("FAIL stall_hold c=%0d: got v=%0b re=%0d im=%0d, want v=1 re=%0d im=%0d",
                        c, out_valid, out_re, out_im, hold_re, hold_im);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (out_re !== 8'(recv + 1) || out_im !== 8'(-(recv + 1))) begin
               errors++;
               $display("FAIL stream_beat %0d: got re=%0d im=%0d, want %0d %0d",
                        recv, $signed(out_re), $signed(out_im), recv + 1, -(recv + 1));
            end
            recv++;
            held = 1'b0;
         end else if (out_valid) begin
            held = 1'b1; hold_re = out_re; hold_im = out_im;
         end else begin
            held = 1'b0;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (sent != 8 || recv != 8) begin
         errors++;
         $display("FAIL stream_count: got sent=%0d recv=%0d, want 8 8", sent, recv);
      end
   endtask

   task automatic watch_frame(input string name, input logic [15:0] want_cnt,
                              input int want_pulses);
      int pulses = 0;
      for (int c = 0; c < 8; c++) begin
         if (frame_done === 1'b1) begin
            pulses++;
            checks++;
            if (frame_ovf_cnt !== want_cnt) begin
               errors++;
               $display("FAIL %s_cnt: got %0d, want %0d", name, frame_ovf_cnt, want_cnt);
            end
         end
         tick();
      end
      checks++;
      if (pulses != want_pulses) begin
         errors++;
         $display("FAIL %s_pulses: got %0d frame_done cycles, want %0d", name, pulses, want_pulses);
      end
   endtask

   task automatic test_frames();
      do_reset();
      send(16'd16,   16'd16, 2'd0, 1'b0);
      send(16'h7FF0, 16'd16, 2'd0, 1'b0);
      send(16'd16,   16'd16, 2'd0, 1'b0);
      send(16'd16,   16'd16, 2'd0, 1'b0);
      send(16'd16,   16'h8000, 2'd0, 1'b1);
      watch_frame("frame1", 16'd2, 1);
      for (int i = 0; i < 4; i++) send(16'd32, 16'd32, 2'd1, (i == 3));
      watch_frame("frame2", 16'd0, 1);
   endtask

   task automatic test_reset_midframe();
      do_reset();
      send(16'h7FF0, 16'd0, 2'd0, 1'b1);
      watch_frame("pre_rst", 16'd1, 1);
      send(16'h7FF0, 16'd0, 2'd0, 1'b0);
      repeat (3) tick();
      out_ready = 1'b0;
      send(16'h7FF0, 16'd0, 2'd0, 1'b0);
      send(16'h7FF0, 16'd0, 2'd0, 1'b1);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_stall: got in_ready=%0b out_valid=%0b, want 0 1", in_ready, out_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || frame_ovf_cnt !== 16'd0 || frame_done !== 1'b0 ||
          ovf_sticky !== 1'b0 || out_re !== 8'd0) begin
         errors++;
         $display("FAIL mid_rst: got v=%0b cnt=%0d done=%0b sticky=%0b re=%0d, want 0 0 0 0 0",
                  out_valid, frame_ovf_cnt, frame_done, ovf_sticky, out_re);
      end
      out_ready = 1'b1;
      watch_frame("post_rst_idle", 16'd0, 0);
      send(16'h7FF0, 16'd0, 2'd0, 1'b0);
      send(16'd16,   16'd0, 2'd0, 1'b0);
      send(16'd16,   16'd0, 2'd0, 1'b1);
      watch_frame("post_rst_frame", 16'd1, 1);
   endtask

   task automatic test_shift0();
      logic [15:0] xv [4] = '{16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF};
      logic [16:0] want_re, want_im;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         for (int m = 0; m < 4; m++) begin
            z_in_re = xv[i]; z_in_im = ~xv[i]; z_in_mode = 2'(m); z_in_valid = 1'b1;
            tick();
            z_in_valid = 1'b0;
            tick();
            want_re = {xv[i][15], xv[i]};
            want_im = {~xv[i][15], ~xv[i]};
            checks++;
            if (z_out_valid !== 1'b1 || z_out_re !== want_re || z_out_im !== want_im ||
                z_out_ovf !== 1'b0) begin
               errors++;
               $display("FAIL shift0 x=%h m=%0d: got v=%0b re=%h im=%h ovf=%0b, want 1 %h %h 0",
                        xv[i], m, z_out_valid, z_out_re, z_out_im, z_out_ovf, want_re, want_im);
            end
            tick();
         end
      end
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_sat_sticky();
      test_back_to_back();
      test_frames();
      test_reset_midframe();
      test_shift0();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/signed_cplx_round_sat.md
Name: signed_cplx_round_sat

Overview:
Pipelined complex requantiser for the FFT/IFFT datapath. Drops SHIFT LSBs from each of re/im, applies a run-time-selectable rounding mode, saturates to OWIDTH, and reports overflow. Uses a valid/ready stream with frame delimiting and keeps per-frame saturation statistics. Sits between butterfly/twiddle-multiply stages and the next stage's input or the output buffer.

Parameters:
IWIDTH, 16, input word width per component (two's complement)
OWIDTH, 16, output word width per component; legal range 2..IWIDTH+1
SHIFT, 0, LSBs discarded (arithmetic right shift); legal range 0..IWIDTH-1
CNT_W, 16, width of per-frame saturation counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_re  in  IWIDTH  real component
in_im  in  IWIDTH  imaginary component
in_mode  in  2  rounding mode, sampled with the beat: 0 truncate (floor), 1 round-half-up, 2 convergent (half-even), 3 treated as 0
in_last  in  1  final beat of frame
in_valid  in  1  beat valid
in_ready  out  1  block accepts beat
out_re  out  OWIDTH  requantised real
out_im  out  OWIDTH  requantised imaginary
out_ovf  out  1  this beat saturated (re or im)
out_last  out  1  in_last delayed with the beat
out_valid  out  1  output valid
out_ready  in  1  downstream accepts
ovf_sticky  out  1  any saturation since reset/clear
ovf_clr  in  1  clears ovf_sticky
frame_ovf_cnt  out  CNT_W  count of saturated beats in last completed frame
frame_done  out  1  one-cycle pulse when frame_ovf_cnt updates

Behaviour:
- Reset (synchronous, rst=1 at clk edge): out_valid=0, out_re=out_im=0, out_ovf=0, out_last=0, ovf_sticky=0, frame_ovf_cnt=0, frame_done=0, running counter=0, both stage valids=0. A frame in flight is discarded; no frame_done for it.
- Pipeline: 2 register stages, latency 2 cycles from accepted input beat to out_valid with no stall.
- Stage 1: add rounding constant in IWIDTH+1 bits (no wrap). Mode 0: +0. Mode 1: +2^(SHIFT-1). Mode 2: +2^(SHIFT-1)-1+x[SHIFT]. SHIFT=0: constant is 0 in all modes.
- Stage 2: arithmetic shift right by SHIFT; saturate to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1]. If the result fits, pass it (sign-extend when OWIDTH > IWIDTH-SHIFT). out_ovf = sat_re | sat_im.
- Handshake: beat transfers on valid&ready at both ports. Stage 2 loads when !v2 | out_ready. Stage 1 loads when !v1 | stage-2 load. in_ready = !v1 | !v2 | out_ready (combinational). Bubbles collapse. Output data is held stable while out_valid & !out_ready.
- Statistics update on output transfers (out_valid&out_ready). The running counter increments if out_ovf and saturates at 2^CNT_W-1. On a transfer with out_last=1: frame_ovf_cnt <= running + out_ovf (saturating), frame_done pulses next cycle, running <= 0.
- ovf_sticky is set on any output transfer with out_ovf. ovf_clr clears it. If clear and set occur in the same cycle, set wins (sticky=1).
- in_mode and in_last travel with their beat; a mode change mid-stream affects only subsequent beats.

Decomposition:
- Shared package: rounding-mode constants (RND_TRUNC=0, RND_HALF_UP=1, RND_CONV=2) and the 2-bit mode typedef; reused by other requantisers in the FFT.
- Sub-module signed_round_sat: single-component 2-stage datapath (round-add, shift, saturate, sat flag) with a stage-enable input. Instantiated twice (re, im). The top level holds handshake, valids, last and statistics.

Test Plan:
- IWIDTH=16, OWIDTH=8, SHIFT=4, no backpressure; re=24, 40, -24 in modes 0/1/2 -> 1/2/2, 2/3/2, -2/-1/-2; out_valid exactly 2 cycles after each accept.
- re=0x7FF0, im=0x8000, mode 1 -> out_re=127, out_im=-128, out_ovf=1, ovf_sticky=1; then ovf_clr pulse together with a saturating beat -> sticky stays 1; ovf_clr alone -> 0.
- Stream of 8 beats, out_ready toggled 1,0,0,1,... -> no beat lost or duplicated, output held stable during stalls, in_ready=0 only when both stages are full and out_ready=0.
- Frame of 5 beats with beats 2 and 5 saturating, in_last on beat 5 -> frame_done one cycle pulse, frame_ovf_cnt=2; next frame with no saturation -> frame_ovf_cnt=0.
- rst asserted mid-frame with both stages full -> next cycle out_valid=0, counters 0, no frame_done; a following 3-beat frame reports its own count only.
- SHIFT=0, OWIDTH=IWIDTH+1 -> output equals sign-extended input in all modes, out_ovf never set.
